// File: rtl/fpu_pkg.sv
// Shared definitions for the binary32 floating-point helpers.
// Contents:
//   f2i_state_t   - state encoding of the sequential float-to-int converter
//   field indices - sign / exponent / fraction positions inside a binary32 word
//   exponent keys - biased exponent values the converter decides on
//   saturation    - 32-bit signed integer limits returned on overflow / NaN
//   shift_count() - number of single-bit shifts that align a significand
package fpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } f2i_state_t;

  // binary32 field positions
  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int FRAC_MSB = 22;

  // Biased exponent keys
  localparam logic [7:0] EXP_ALL_ONES  = 8'hFF;   // inf / NaN
  localparam logic [7:0] EXP_UNITY_LSB = 8'd150;  // E = 23: significand LSB has weight 1
  localparam logic [7:0] EXP_OVF       = 8'd158;  // E = 31: magnitude >= 2^31

  // Saturation values and the one binary32 that is exactly INT32_MIN
  localparam logic [31:0] SAT_POS     = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_NEG     = 32'h8000_0000;
  localparam logic [31:0] INT_MIN_F32 = 32'hCF00_0000;

  // |E - 23| for a biased exponent; callers only use it for E in -1..30,
  // where the result fits in five bits.
  function automatic logic [4:0] shift_count(input logic [7:0] exp_field);
    if (exp_field > EXP_UNITY_LSB) begin
      shift_count = 5'(exp_field - EXP_UNITY_LSB);
    end else begin
      shift_count = 5'(EXP_UNITY_LSB - exp_field);
    end
  endfunction

endpackage

// File: rtl/fpu_f2i_classify.sv
// Combinational special-operand detector for binary32 -> int32 conversion.
// Operands whose result is known without any shifting are flagged here
// together with their final result and invalid flag.
// Ports:
//   a           in  [31:0] binary32 operand
//   is_special  out        operand bypasses the shift/round datapath
//   special_res out [31:0] result for a special operand (0 otherwise)
//   special_nv  out        invalid flag for a special operand (0 otherwise)
// Configuration: FPU_F2I_RNE_EN defined -> E = -1 (0.5 <= |a| < 1) is not
// special, because round-to-nearest can turn it into +/-1.
module fpu_f2i_classify
  import fpu_pkg::*;
(
  input  logic [31:0] a,
  output logic        is_special,
  output logic [31:0] special_res,
  output logic        special_nv
);

  // Smallest biased exponent that still needs the datapath.
`ifdef FPU_F2I_RNE_EN
  localparam logic [7:0] EXP_SMALL_LIM = 8'd126;
`else
  localparam logic [7:0] EXP_SMALL_LIM = 8'd127;
`endif

  logic [7:0]  exp_s;
  logic [22:0] frac_s;
  logic        sign_s;

  assign exp_s  = a[EXP_MSB:EXP_LSB];
  assign frac_s = a[FRAC_MSB:0];
  assign sign_s = a[SIGN_BIT];

  // Priority decode of the special classes.
  always_comb begin
    is_special  = 1'b0;
    special_res = 32'd0;
    special_nv  = 1'b0;
    if (exp_s == EXP_ALL_ONES) begin
      is_special = 1'b1;
      special_nv = 1'b1;
      if (frac_s != 23'd0) begin
        special_res = SAT_POS;           // NaN always saturates positive
      end else if (sign_s) begin
        special_res = SAT_NEG;
      end else begin
        special_res = SAT_POS;
      end
    end else if (exp_s >= EXP_OVF) begin
      is_special = 1'b1;
      if (!sign_s) begin
        special_res = SAT_POS;
        special_nv  = 1'b1;
      end else if (a == INT_MIN_F32) begin
        special_res = SAT_NEG;           // exactly -2^31 is representable
        special_nv  = 1'b0;
      end else begin
        special_res = SAT_NEG;
        special_nv  = 1'b1;
      end
    end else if (exp_s < EXP_SMALL_LIM) begin
      // zero, denormal, or too small to reach magnitude 1
      is_special  = 1'b1;
      special_res = 32'd0;
      special_nv  = 1'b0;
    end else begin
      is_special  = 1'b0;
      special_res = 32'd0;
      special_nv  = 1'b0;
    end
  end

endmodule

// File: rtl/fpu_f2i_seq.sv
// Sequential binary32 -> int32 converter (FCVT.W.S semantics).
// The 24-bit significand is aligned one bit per cycle, so a normal operand
// takes |E-23| SHIFT cycles, one ROUND cycle, then a DONE cycle.
// Special operands skip straight to DONE.
// Ports:
//   clk   in         rising-edge clock
//   rst   in         synchronous active-high reset, overrides start
//   start in         request, accepted in IDLE or DONE only
//   a     in  [31:0] binary32 operand, sampled on the accepting edge
//   rm    in         0 = RTZ, 1 = RNE (only with FPU_F2I_RNE_EN)
//   res   out [31:0] signed result, held until the next accepted start
//   nv    out        invalid flag, valid with done
//   busy  out        high in SHIFT and ROUND
//   done  out        one-cycle completion pulse
// Configuration: FPU_F2I_RNE_EN enables guard/sticky tracking and the
// round-to-nearest-even increment; without it every result is truncated.
module fpu_f2i_seq
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic        rm,
  output logic [31:0] res,
  output logic        nv,
  output logic        busy,
  output logic        done
);

  f2i_state_t  state_r, state_n;
  logic [31:0] mag_r, mag_n;        // aligned magnitude (up to 2^31 - 2^7)
  logic [4:0]  cnt_r, cnt_n;        // remaining shifts
  logic        left_r, left_n;      // shift direction
  logic        sign_r, sign_n;
  logic [31:0] res_r, res_n;
  logic        nv_r, nv_n;
  logic        busy_r, busy_n;
  logic        done_r, done_n;

  logic        accept_s;
  logic        is_special_s;
  logic [31:0] special_res_s;
  logic        special_nv_s;
  logic [4:0]  k_s;
  logic        left_s;
  logic [31:0] rounded_s;

`ifdef FPU_F2I_RNE_EN
  logic        guard_r, guard_n;    // last bit shifted out
  logic        sticky_r, sticky_n;  // OR of all earlier shifted-out bits
  logic        rm_r, rm_n;
  logic        round_up_s;
`else
  logic        rm_unused_s;
  assign rm_unused_s = rm;
`endif

  fpu_f2i_classify u_classify (
    .a           (a),
    .is_special  (is_special_s),
    .special_res (special_res_s),
    .special_nv  (special_nv_s)
  );

  assign accept_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign k_s      = shift_count(a[EXP_MSB:EXP_LSB]);
  assign left_s   = (a[EXP_MSB:EXP_LSB] > EXP_UNITY_LSB);

`ifdef FPU_F2I_RNE_EN
  // Ties go to the even neighbour: round up on guard unless exactly half with even LSB.
  assign round_up_s = rm_r & guard_r & (sticky_r | mag_r[0]);
  assign rounded_s  = mag_r + {31'd0, round_up_s};
`else
  assign rounded_s  = mag_r;
`endif

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so that they can be driven straight from registers.
  always_comb begin
    state_n  = state_r;
    mag_n    = mag_r;
    cnt_n    = cnt_r;
    left_n   = left_r;
    sign_n   = sign_r;
    res_n    = res_r;
    nv_n     = nv_r;
    busy_n   = 1'b0;
    done_n   = 1'b0;
`ifdef FPU_F2I_RNE_EN
    guard_n  = guard_r;
    sticky_n = sticky_r;
    rm_n     = rm_r;
`endif
    if (accept_s) begin
      mag_n  = {8'd0, 1'b1, a[FRAC_MSB:0]};
      cnt_n  = k_s;
      left_n = left_s;
      sign_n = a[SIGN_BIT];
`ifdef FPU_F2I_RNE_EN
      guard_n  = 1'b0;
      sticky_n = 1'b0;
      rm_n     = rm;
`endif
      if (is_special_s) begin
        state_n = ST_DONE;
        done_n  = 1'b1;
        res_n   = special_res_s;
        nv_n    = special_nv_s;
      end else if (k_s == 5'd0) begin
        state_n = ST_ROUND;             // E = 23: already aligned
        busy_n  = 1'b1;
      end else begin
        state_n = ST_SHIFT;
        busy_n  = 1'b1;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_n = ST_IDLE;
        end
        ST_SHIFT: begin
          busy_n = 1'b1;
          cnt_n  = cnt_r - 5'd1;
          if (left_r) begin
            mag_n = {mag_r[30:0], 1'b0};
          end else begin
            mag_n = {1'b0, mag_r[31:1]};
`ifdef FPU_F2I_RNE_EN
            guard_n  = mag_r[0];
            sticky_n = sticky_r | guard_r;
`endif
          end
          if (cnt_r == 5'd1) begin
            state_n = ST_ROUND;
          end else begin
            state_n = ST_SHIFT;
          end
        end
        ST_ROUND: begin
          state_n = ST_DONE;
          done_n  = 1'b1;
          nv_n    = 1'b0;
          if (sign_r) begin
            res_n = 32'd0 - rounded_s;
          end else begin
            res_n = rounded_s;
          end
        end
        ST_DONE: begin
          state_n = ST_IDLE;
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  // State, datapath and output registers; rst wins over any start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      mag_r    <= 32'd0;
      cnt_r    <= 5'd0;
      left_r   <= 1'b0;
      sign_r   <= 1'b0;
      res_r    <= 32'd0;
      nv_r     <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
`ifdef FPU_F2I_RNE_EN
      guard_r  <= 1'b0;
      sticky_r <= 1'b0;
      rm_r     <= 1'b0;
`endif
    end else begin
      state_r  <= state_n;
      mag_r    <= mag_n;
      cnt_r    <= cnt_n;
      left_r   <= left_n;
      sign_r   <= sign_n;
      res_r    <= res_n;
      nv_r     <= nv_n;
      busy_r   <= busy_n;
      done_r   <= done_n;
`ifdef FPU_F2I_RNE_EN
      guard_r  <= guard_n;
      sticky_r <= sticky_n;
      rm_r     <= rm_n;
`endif
    end
  end

  assign res  = res_r;
  assign nv   = nv_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_fpu_f2i_seq.sv
// Self-checking bench for fpu_f2i_seq: directed corner cases followed by
// randomized operands compared against an arithmetic reference model.
module tb_fpu_f2i_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic        rm;
  logic [31:0] res;
  logic        nv;
  logic        busy;
  logic        done;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] last_res = 32'd0;
  logic        last_nv  = 1'b0;

`ifdef FPU_F2I_RNE_EN
  localparam bit RNE_BUILD = 1'b1;
`else
  localparam bit RNE_BUILD = 1'b0;
`endif

  always #5 clk = ~clk;

  fpu_f2i_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .rm    (rm),
    .res   (res),
    .nv    (nv),
    .busy  (busy),
    .done  (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: exact value m * 2^(E-23), rounded by comparing the discarded
  // remainder against one half, then range-checked against int32.
  task automatic ref_model(input logic [31:0] av, input logic rmv,
                           output logic [31:0] r, output logic n, output int lat);
    int     e;
    int     sh;
    longint m, mag, rem, half, val;
    logic [7:0] ex;
    ex  = av[30:23];
    e   = int'(ex) - 127;
    m   = longint'({1'b1, av[22:0]});
    mag = 0;
    if (ex == 8'hFF || e >= 31 || ex == 8'h00 || e < (RNE_BUILD ? -1 : 0)) lat = 1;
    else lat = ((e > 23) ? (e - 23) : (23 - e)) + 2;
    if (ex == 8'hFF && av[22:0] != 23'd0) begin
      r = 32'h7FFF_FFFF; n = 1'b1;
    end else if (ex == 8'hFF) begin
      r = av[31] ? 32'h8000_0000 : 32'h7FFF_FFFF; n = 1'b1;
    end else begin
      if (ex == 8'h00 || e < -1) mag = 0;
      else if (e >= 40) mag = longint'(1) << 40;
      else if (e >= 23) mag = m << (e - 23);
      else begin
        sh   = 23 - e;
        mag  = m >> sh;
        rem  = m & ((longint'(1) << sh) - 1);
        half = longint'(1) << (sh - 1);
        if (RNE_BUILD && rmv && (rem > half || (rem == half && mag[0]))) mag = mag + 1;
      end
      val = av[31] ? -mag : mag;
      if (val > 64'sd2147483647) begin
        r = 32'h7FFF_FFFF; n = 1'b1;
      end else if (val < -64'sd2147483648) begin
        r = 32'h8000_0000; n = 1'b1;
      end else begin
        r = val[31:0]; n = 1'b0;
      end
    end
  endtask

  // Issue one operation and follow it to done, checking busy every cycle,
  // then latency, result and flag. Leaves the bench in the DONE cycle.
  task automatic run_op(input logic [31:0] av, input logic rmv, input logic [31:0] er,
                        input logic en, input int el, input string tag);
    int cyc;
    @(negedge clk);
    start = 1'b1; a = av; rm = rmv;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; rm = 1'($urandom);   // operand must already be captured
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      check({tag, " busy"}, {31'd0, busy}, (cyc < el) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " latency"}, cyc, el);
    check({tag, " res"}, res, er);
    check({tag, " nv"}, {31'd0, nv}, {31'd0, en});
    check({tag, " busy@done"}, {31'd0, busy}, 32'd0);
    last_res = er;
    last_nv  = en;
  endtask

  task automatic run_model(input logic [31:0] av, input logic rmv, input string tag);
    logic [31:0] er;
    logic        en;
    int          el;
    ref_model(av, rmv, er, en, el);
    run_op(av, rmv, er, en, el, tag);
  endtask

  // One idle cycle: done must have dropped and the result must be held.
  task automatic idle_check(input string tag);
    @(posedge clk); #1;
    check({tag, " hold res"}, res, last_res);
    check({tag, " hold nv"}, {31'd0, nv}, {31'd0, last_nv});
    check({tag, " idle done"}, {31'd0, done}, 32'd0);
    check({tag, " idle busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] av;
    rst = 1'b1; start = 1'b0; a = 32'd0; rm = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset res", res, 32'd0);
    check("reset nv", {31'd0, nv}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Normal operands: 15.0 has E=3 (k=20), -1005.0 has E=9 (k=14)
    run_op(32'h4170_0000, 1'b0, 32'h0000_000F, 1'b0, 22, "15.0");
    idle_check("after 15.0");
    run_op(32'hC47B_4000, 1'b0, 32'hFFFF_FC13, 1'b0, 16, "-1005.0");
    idle_check("after -1005.0");
    run_op(32'h4B00_0001, 1'b0, 32'h0080_0001, 1'b0, 2, "E=23");
    run_op(32'h4EFF_FFFF, 1'b0, 32'h7FFF_FF80, 1'b0, 9, "E=30 max");

    // Specials, each one cycle
    run_op(32'h7FC0_0000, 1'b0, 32'h7FFF_FFFF, 1'b1, 1, "NaN");
    run_op(32'h4F00_0000, 1'b0, 32'h7FFF_FFFF, 1'b1, 1, "+2^31");
    run_op(32'hCF00_0000, 1'b0, 32'h8000_0000, 1'b0, 1, "-2^31");
    run_op(32'hCF00_0001, 1'b0, 32'h8000_0000, 1'b1, 1, "neg ovf");
    run_op(32'hFF80_0000, 1'b0, 32'h8000_0000, 1'b1, 1, "-inf");
    run_op(32'h8000_0000, 1'b0, 32'h0000_0000, 1'b0, 1, "-0");
    run_op(32'h3E80_0000, 1'b1, 32'h0000_0000, 1'b0, 1, "0.25");

    // Rounding: 3.5 and 2.5 have E=1 (k=22); 0.75 has E=-1 (k=24 with RNE)
`ifdef FPU_F2I_RNE_EN
    run_op(32'h4060_0000, 1'b1, 32'd4, 1'b0, 24, "3.5 rne");
    run_op(32'h4020_0000, 1'b1, 32'd2, 1'b0, 24, "2.5 rne");
    run_op(32'hC020_0000, 1'b1, 32'hFFFF_FFFE, 1'b0, 24, "-2.5 rne");
    run_op(32'h3F40_0000, 1'b1, 32'd1, 1'b0, 26, "0.75 rne");
    run_op(32'h3F40_0000, 1'b0, 32'd0, 1'b0, 26, "0.75 rtz");
`else
    run_op(32'h4060_0000, 1'b1, 32'd3, 1'b0, 24, "3.5 rm ignored");
    run_op(32'h4020_0000, 1'b1, 32'd2, 1'b0, 24, "2.5 rm ignored");
    run_op(32'h3F40_0000, 1'b1, 32'd0, 1'b0, 1, "0.75 small");
`endif
    run_op(32'h4060_0000, 1'b0, 32'd3, 1'b0, 24, "3.5 rtz");

    // Back-to-back: run_op returns in the DONE cycle, so the next start
    // lands there. 1.0 has E=0, so k=23 and done follows 25 cycles later.
    run_op(32'h4170_0000, 1'b0, 32'h0000_000F, 1'b0, 22, "b2b first");
    run_op(32'h3F80_0000, 1'b0, 32'h0000_0001, 1'b0, 25, "b2b 1.0");
    idle_check("after b2b");

    // Abort: reset during a 15.0 conversion, start during busy ignored
    @(negedge clk);
    start = 1'b1; a = 32'h4170_0000; rm = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check("abort busy c1", {31'd0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b1; a = 32'h3F80_0000;
    @(posedge clk); #1;
    start = 1'b0;
    check("ignored start busy", {31'd0, busy}, 32'd1);
    check("ignored start done", {31'd0, done}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; start = 1'b1; a = 32'h3F80_0000;     // rst must beat start
    @(posedge clk); #1;
    check("abort res", res, 32'd0);
    check("abort nv", {31'd0, nv}, 32'd0);
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      check("no done after abort", {31'd0, done}, 32'd0);
      check("no busy after abort", {31'd0, busy}, 32'd0);
    end
    last_res = 32'd0;
    last_nv  = 1'b0;

    // Randomized operands, mostly around the interesting exponent range
    for (int i = 0; i < 150; i++) begin
      av = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5, 6: av[30:23] = 8'($urandom_range(124, 160));
        7:                   av[30:23] = av[30:23];
        8:                   av[30:23] = 8'hFF;
        9:                   av[30:23] = 8'($urandom_range(0, 3));
        default:             av[30:23] = 8'd127;
      endcase
      run_model(av, 1'($urandom), "random");
      if ($urandom_range(0, 1) == 1) idle_check("random gap");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
